// File: rtl/fpa_pkg.sv
// Shared constants and types for the fpa_pack normalize/round/pack back end.
// Optional flags output is controlled by FPA_PACK_FLAGS_EN (see fpa_pack.sv).
package fpa_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MAN_W  = FRAC_W + 5;
    localparam int WORD_W = 1 + EXP_W + FRAC_W;

    // Two spare bits let the working exponent exceed 255 before saturation.
    localparam int EXP_IW = EXP_W + 2;

    localparam int CARRY_BIT  = MAN_W - 1;
    localparam int HIDDEN_BIT = MAN_W - 2;
    localparam int GUARD_BIT  = 2;
    localparam int EXP_MAX    = (1 << EXP_W) - 1;

    localparam int FLAG_OVF  = 3;
    localparam int FLAG_UNF  = 2;
    localparam int FLAG_INX  = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fpa_pack_if.sv
// Handshake bundle between the fpa result producer and fpa_pack.
// The flags field exists only when FPA_PACK_FLAGS_EN is defined.
interface fpa_pack_if;
    import fpa_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic                in_sign;
    logic [EXP_W-1:0]    in_exp;
    logic [MAN_W-1:0]    in_mantis;

    logic                out_valid;
    logic                out_ready;
    logic [WORD_W-1:0]   out_word;
`ifdef FPA_PACK_FLAGS_EN
    logic [3:0]          flags;

    modport master (
        output in_valid, in_sign, in_exp, in_mantis, out_ready,
        input  in_ready, out_valid, out_word, flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mantis, out_ready,
        output in_ready, out_valid, out_word, flags
    );
`else
    modport master (
        output in_valid, in_sign, in_exp, in_mantis, out_ready,
        input  in_ready, out_valid, out_word
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mantis, out_ready,
        output in_ready, out_valid, out_word
    );
`endif

endinterface

// File: rtl/fpa_round.sv
// Combinational round-to-nearest-even plus exponent adjust and IEEE packing.
// Exposes status flags only when FPA_PACK_FLAGS_EN is defined.
module fpa_round
    import fpa_pkg::*;
(
    input  logic                  sign,
    input  logic [EXP_IW-1:0]     exp,
    input  logic [HIDDEN_BIT:0]   mantis,
    output logic [WORD_W-1:0]     word
`ifdef FPA_PACK_FLAGS_EN
    ,
    output logic [3:0]            flags
`endif
);

    function automatic logic rne_inc(input logic lsb, input logic g,
                                     input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction

    logic                 inc;
    logic [FRAC_W+1:0]    sum;
    logic [FRAC_W:0]      sig;
    logic [EXP_IW-1:0]    exp_r;
    logic                 ovf;
    logic [EXP_W-1:0]     exp_field;

    always_comb begin
        inc       = rne_inc(mantis[GUARD_BIT+1], mantis[GUARD_BIT],
                            mantis[GUARD_BIT-1], mantis[GUARD_BIT-2]);
        sum       = {1'b0, mantis[HIDDEN_BIT:GUARD_BIT+1]} + {{(FRAC_W+1){1'b0}}, inc};
        sig       = sum[FRAC_W:0];
        exp_r     = exp;
        // Rounding all-ones up carries out: renormalize by one place.
        if (sum[FRAC_W+1]) begin
            sig   = sum[FRAC_W+1:1];
            exp_r = exp + EXP_IW'(1);
        end
        ovf       = (exp_r >= EXP_IW'(EXP_MAX));
        exp_field = sig[FRAC_W] ? exp_r[EXP_W-1:0] : '0;
        if (ovf) begin
            word = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            word = {sign, exp_field, sig[FRAC_W-1:0]};
        end
    end

`ifdef FPA_PACK_FLAGS_EN
    // Bits lost by the single right shift are already folded into the sticky bit.
    logic inexact;

    always_comb begin
        inexact            = |mantis[GUARD_BIT:0];
        flags              = '0;
        flags[FLAG_OVF]    = ovf;
        flags[FLAG_INX]    = inexact;
        flags[FLAG_UNF]    = (word[WORD_W-2 -: EXP_W] == '0) && inexact;
        flags[FLAG_ZERO]   = (word[WORD_W-2:0] == '0);
    end
`endif

endmodule

// File: rtl/fpa_pack.sv
// Iterative normalizer (one shift per cycle) feeding an RNE rounder and packer.
// Define FPA_PACK_FLAGS_EN to add {overflow, underflow, inexact, zero} flags.
module fpa_pack
    import fpa_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    fpa_pack_if.slave  bus
);

    state_t               state_q;
    state_t               state_d;

    logic                 sign_q;
    logic [EXP_IW-1:0]    exp_q;
    logic [MAN_W-1:0]     man_q;
    logic [WORD_W-1:0]    word_q;
    logic [WORD_W-1:0]    rnd_word;

    logic                 accept;
    logic                 shift_r;
    logic                 shift_l;

`ifdef FPA_PACK_FLAGS_EN
    logic [3:0]           flags_q;
    logic [3:0]           rnd_flags;
`endif

    // Next-state and one normalize action per NORM cycle, in priority order.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        shift_r = 1'b0;
        shift_l = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (man_q == '0) begin
                    state_d = ROUND;
                end else if (man_q[CARRY_BIT]) begin
                    shift_r = 1'b1;
                end else if (!man_q[HIDDEN_BIT] && (exp_q > EXP_IW'(1))) begin
                    shift_l = 1'b1;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
`ifdef FPA_PACK_FLAGS_EN
            flags_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == ROUND) begin
                word_q  <= rnd_word;
`ifdef FPA_PACK_FLAGS_EN
                flags_q <= rnd_flags;
`endif
            end
        end
    end

    // Operand registers; a zero exponent is treated as the subnormal exponent 1.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_q <= bus.in_sign;
            exp_q  <= (bus.in_exp == '0) ? EXP_IW'(1) : EXP_IW'(bus.in_exp);
            man_q  <= bus.in_mantis;
        end else if (shift_r) begin
            man_q  <= {1'b0, man_q[MAN_W-1:2], man_q[1] | man_q[0]};
            exp_q  <= exp_q + EXP_IW'(1);
        end else if (shift_l) begin
            man_q  <= {man_q[MAN_W-2:0], 1'b0};
            exp_q  <= exp_q - EXP_IW'(1);
        end
    end

    fpa_round u_round (
        .sign   (sign_q),
        .exp    (exp_q),
        .mantis (man_q[HIDDEN_BIT:0]),
        .word   (rnd_word)
`ifdef FPA_PACK_FLAGS_EN
        ,
        .flags  (rnd_flags)
`endif
    );

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_word  = word_q;
`ifdef FPA_PACK_FLAGS_EN
    assign bus.flags     = flags_q;
`endif

endmodule

// File: tb/tb_fpa_pack.sv
// Self-checking bench for fpa_pack: arithmetic reference model, directed and random operands.
// Flags are checked too when FPA_PACK_FLAGS_EN is defined.
module tb_fpa_pack;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpa_pack_if bif();

    fpa_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        logic [31:0] word;
        logic [3:0]  flags;
        int          k;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;
    bit   seen     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Value-level reference: exact integer normalization, then remainder-based RNE.
    function automatic exp_t model(input bit s, input int e_in, input longint m_in);
        exp_t   r;
        longint m    = m_in;
        int     e    = (e_in == 0) ? 1 : e_in;
        int     k    = 0;
        longint keep;
        longint rem;
        bit     inx;
        bit     ovf;
        if (m != 0) begin
            if (m >= (64'd1 << 27)) begin
                m = (m >> 1) | (m & 1);
                e++;
                k++;
            end
            while (m < (64'd1 << 26) && e > 1) begin
                m = m << 1;
                e--;
                k++;
            end
        end
        keep = m >> 3;
        rem  = m & 7;
        if (rem > 4 || (rem == 4 && (keep & 1) == 1)) keep++;
        if (keep >= (64'd1 << 24)) begin
            keep = keep >> 1;
            e++;
        end
        inx = (rem != 0);
        ovf = (e >= 255);
        if (ovf)                        r.word = {s, 8'hFF, 23'h0};
        else if (keep >= (64'd1 << 23)) r.word = {s, e[7:0], keep[22:0]};
        else                            r.word = {s, 8'h00, keep[22:0]};
        r.flags = {ovf, (r.word[30:23] == 8'h00) && inx, inx, (r.word[30:0] == 31'h0)};
        r.k     = k;
        r.acc   = 0;
        return r;
    endfunction

    // Accept/retire monitor at the active edge (sees pre-edge values).
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            edge_n = edge_n + 1;
            if (rst) begin
                q.delete();
                seen = 1'b0;
            end else begin
                if (bif.out_valid && bif.out_ready && q.size() > 0) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
                if (bif.in_valid && bif.in_ready) begin
                    e     = model(bif.in_sign, int'(bif.in_exp), longint'(bif.in_mantis));
                    e.acc = edge_n;
                    q.push_back(e);
                end
            end
        end
    end

    // Compare process: every cycle the output is valid.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bif.out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got word %h with no pending operand", bif.out_word);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        check("latency_edge", 32'(edge_n), 32'(q[0].acc + 2 + q[0].k));
                    end
                    check("out_word", bif.out_word, q[0].word);
`ifdef FPA_PACK_FLAGS_EN
                    check("flags", {28'h0, bif.flags}, {28'h0, q[0].flags});
`endif
                    check("in_ready_busy", {31'h0, bif.in_ready}, 32'h0);
                end
            end
        end
    end

    task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m);
        int t = 0;
        bif.in_sign   = s;
        bif.in_exp    = e;
        bif.in_mantis = m;
        bif.in_valid  = 1'b1;
        @(negedge clk);
        while (!bif.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bif.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready=%b, required 1 within 200 cycles", bif.in_ready);
        end
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int t = 0;
        while ((q.size() != 0 || bif.out_valid) && t < 300) begin
            bif.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (t >= 300) begin
            failures++;
            $display("FAIL drain_timeout: pending=%0d, required 0", q.size());
        end
    endtask

    task automatic pin(input string name, input bit s, input int e, input longint m,
                       input logic [31:0] w, input int k);
        exp_t r = model(s, e, m);
        check({name, "_word"}, r.word, w);
        check({name, "_k"}, 32'(r.k), 32'(k));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold;
        logic [27:0] m;
        logic [7:0]  e;
        int          t;

        rst           = 1'b1;
        bif.in_valid  = 1'b0;
        bif.in_sign   = 1'b0;
        bif.in_exp    = '0;
        bif.in_mantis = '0;
        bif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'h0, bif.in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, bif.out_valid}, 32'h0);
        check("rst_out_word", bif.out_word, 32'h0);
`ifdef FPA_PACK_FLAGS_EN
        check("rst_flags", {28'h0, bif.flags}, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Hand-computed values that pin the reference model.
        pin("one",      0, 127, 64'h4000000, 32'h3F800000, 0);
        pin("carry",    0, 127, 64'h8000000, 32'h40000000, 1);
        pin("ovf",      0, 254, 64'h8000000, 32'h7F800000, 1);
        pin("lshift3",  0, 130, 64'h0800000, 32'h3F800000, 3);
        pin("tie_even", 0, 127, 64'h4000004, 32'h3F800000, 0);
        pin("tie_odd",  0, 127, 64'h400000C, 32'h3F800002, 0);
        pin("rnd_cry",  0, 127, 64'h7FFFFFC, 32'h40000000, 0);
        pin("neg_zero", 1, 127, 64'h0,       32'h80000000, 0);
        // 2^-127 lands in the subnormal range as fraction 2^22.
        pin("subnorm",  0, 2,   64'h1000000, 32'h00400000, 1);
        begin
            exp_t r = model(0, 254, 64'h8000000);
            check("ovf_flags", {28'h0, r.flags}, 32'h8);
            r = model(1, 127, 64'h0);
            check("zero_flags", {28'h0, r.flags}, 32'h1);
        end

        // Directed operands through the DUT.
        send(0, 8'd127, 28'h4000000); drain(0);
        send(0, 8'd127, 28'h8000000); drain(0);
        send(0, 8'd254, 28'h8000000); drain(0);
        send(0, 8'd130, 28'h0800000); drain(0);
        send(0, 8'd127, 28'h4000004); drain(0);
        send(0, 8'd127, 28'h400000C); drain(0);
        send(0, 8'd127, 28'h7FFFFFC); drain(0);
        send(1, 8'd127, 28'h0000000); drain(0);
        send(0, 8'd2,   28'h1000000); drain(0);
        send(1, 8'd0,   28'h0000001); drain(0);
        send(0, 8'd1,   28'h3FFFFFC); drain(0);

        // Backpressure: result must hold while the consumer stalls.
        bif.out_ready = 1'b0;
        send(0, 8'd127, 28'h400000C);
        t = 0;
        while (!bif.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp_valid", {31'h0, bif.out_valid}, 32'h1);
        hold = bif.out_word;
        repeat (5) begin
            @(negedge clk);
            check("bp_stable", bif.out_word, hold);
            check("bp_in_ready", {31'h0, bif.in_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        drain(0);

        // Reset in the middle of normalization drops the operand.
        send(0, 8'd130, 28'h0800000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_in_ready", {31'h0, bif.in_ready}, 32'h1);
        check("mid_rst_out_valid", {31'h0, bif.out_valid}, 32'h0);
        repeat (8) begin
            @(negedge clk);
            check("mid_rst_quiet", {31'h0, bif.out_valid}, 32'h0);
        end
        @(posedge clk);
        #1;

        // Randomized operands with random consumer stalls.
        for (int i = 0; i < 160; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    m = 28'($urandom);
                    e = 8'($urandom);
                end
                1: begin
                    m = 28'($urandom >> $urandom_range(4, 31));
                    e = 8'($urandom_range(0, 40));
                end
                2: begin
                    m = 28'($urandom) | 28'h4000000;
                    e = 8'($urandom_range(248, 255));
                end
                default: begin
                    m = ($urandom_range(0, 1) == 0) ? 28'h0 : 28'($urandom_range(0, 15));
                    e = 8'($urandom_range(0, 254));
                end
            endcase
            send(1'($urandom), e, m);
            drain(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
